cory_rrarb4: RTL

- 4-input round-robin arbiter/merge for valid/ready streams. It is the counterpart of the duplicator tree: it shares one downstream consumer between four producers.
- One registered output stage. Each output beat carries the winner's data and its source index.
- Used to funnel results from parallel branches back into one pipe.
- Optional packet lock: a multi-beat transfer from one source stays uninterleaved.

---
 rtl/cory_rrarb4.sv | 121 ++++++++++++
 1 files changed

// File: rtl/cory_rrarb4.sv
// 4-input round-robin merge for valid/ready streams with one registered output stage.
// Define CORY_RRARB_LOCK_EN to keep multi-beat packets from one source uninterleaved.
module cory_rrarb4 #(
    parameter int unsigned N  = 16,
    parameter logic [1:0]  P0 = 2'd0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_a0_v,
    input  logic [N-1:0] i_a0_d,
    input  logic         i_a0_l,
    output logic         o_a0_r,
    input  logic         i_a1_v,
    input  logic [N-1:0] i_a1_d,
    input  logic         i_a1_l,
    output logic         o_a1_r,
    input  logic         i_a2_v,
    input  logic [N-1:0] i_a2_d,
    input  logic         i_a2_l,
    output logic         o_a2_r,
    input  logic         i_a3_v,
    input  logic [N-1:0] i_a3_d,
    input  logic         i_a3_l,
    output logic         o_a3_r,
    output logic         o_z_v,
    output logic [N-1:0] o_z_d,
    output logic [1:0]   o_z_id,
    output logic         o_z_l,
    input  logic         i_z_r
);

    logic [3:0]   in_v;
    logic [3:0]   in_l;
    logic [N-1:0] in_d [4];
    logic [3:0]   gnt;
    logic [1:0]   ptr_q;
    logic [1:0]   win;
    logic [1:0]   idx;
    logic         any;
    logic         ld;
    logic [N-1:0] sel_d;
    logic         sel_l;

`ifdef CORY_RRARB_LOCK_EN
    logic         lock_q;
    logic [1:0]   lockid_q;
`endif

    assign in_v  = {i_a3_v, i_a2_v, i_a1_v, i_a0_v};
    assign in_l  = {i_a3_l, i_a2_l, i_a1_l, i_a0_l};
    assign in_d[0] = i_a0_d;
    assign in_d[1] = i_a1_d;
    assign in_d[2] = i_a2_d;
    assign in_d[3] = i_a3_d;

    // Output register is empty or being drained this cycle.
    assign ld = ~o_z_v | i_z_r;

    always_comb begin
        gnt = '0;
        win = ptr_q;
        idx = ptr_q;
        any = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!any && in_v[idx]) begin
                gnt[idx] = 1'b1;
                win      = idx;
                any      = 1'b1;
            end
        end
`ifdef CORY_RRARB_LOCK_EN
        // A packet in flight owns the output; everyone else waits even if it stalls.
        if (lock_q) begin
            gnt           = '0;
            gnt[lockid_q] = in_v[lockid_q];
            win           = lockid_q;
            any           = in_v[lockid_q];
        end
`endif
    end

    assign sel_d = in_d[win];
    assign sel_l = in_l[win];

    assign o_a0_r = reset_n & ld & gnt[0];
    assign o_a1_r = reset_n & ld & gnt[1];
    assign o_a2_r = reset_n & ld & gnt[2];
    assign o_a3_r = reset_n & ld & gnt[3];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_z_v    <= 1'b0;
            o_z_d    <= '0;
            o_z_id   <= 2'd0;
            o_z_l    <= 1'b0;
            ptr_q    <= P0;
`ifdef CORY_RRARB_LOCK_EN
            lock_q   <= 1'b0;
            lockid_q <= 2'd0;
`endif
        end else if (ld) begin
            o_z_v <= any;
            if (any) begin
                o_z_d  <= sel_d;
                o_z_id <= win;
                o_z_l  <= sel_l;
`ifdef CORY_RRARB_LOCK_EN
                lock_q   <= ~sel_l;
                lockid_q <= win;
                if (sel_l) begin
                    ptr_q <= win + 2'd1;
                end
`else
                ptr_q <= win + 2'd1;
`endif
            end
        end
    end

endmodule
